boot_ram_loader: RTL and testbench

- AXI4 write-burst master that copies the boot image from a synchronous ROM into the internal SRAM through the data-side AXI write port of the internal memory block.
- Holds the CPU in reset until the copy completes without error.
- Sits directly upstream of the internal memory's d_axi write channels; read channels are not driven by this block.

---
 rtl/boot_ram_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_boot_ram_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_ram_loader.sv
// boot_ram_loader: copies the boot image from a synchronous ROM into SRAM via AXI4
// INCR write bursts and holds the CPU in reset until the copy finishes cleanly.
// Optional build macro BOOT_RAM_LOADER_CHECKSUM_EN adds a 32-bit sum of all written
// beats on checksum_o; otherwise checksum_o is tied to 0.
module boot_ram_loader #(
    parameter int unsigned     ADDR_W     = 32,
    parameter int unsigned     DATA_W     = 32,
    parameter int unsigned     AXI_ID_W   = 8,
    parameter int unsigned     ROM_ADDR_W = 10,
    parameter int unsigned     BURST_LEN  = 16,
    parameter longint unsigned DEST_BASE  = 0
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  cpu_reset_o,
    output logic [31:0]           checksum_o,
    output logic                  rom_en_o,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0]     rom_rdata_i,
    output logic [AXI_ID_W-1:0]   m_axi_awid_o,
    output logic [ADDR_W-1:0]     m_axi_awaddr_o,
    output logic [7:0]            m_axi_awlen_o,
    output logic [2:0]            m_axi_awsize_o,
    output logic [1:0]            m_axi_awburst_o,
    output logic                  m_axi_awvalid_o,
    input  logic                  m_axi_awready_i,
    output logic [DATA_W-1:0]     m_axi_wdata_o,
    output logic [DATA_W/8-1:0]   m_axi_wstrb_o,
    output logic                  m_axi_wlast_o,
    output logic                  m_axi_wvalid_o,
    input  logic                  m_axi_wready_i,
    input  logic [AXI_ID_W-1:0]   m_axi_bid_i,
    input  logic [1:0]            m_axi_bresp_i,
    input  logic                  m_axi_bvalid_i,
    output logic                  m_axi_bready_o
);

    localparam int unsigned     STRB_W      = DATA_W / 8;
    localparam int unsigned     BURST_BYTES = BURST_LEN * STRB_W;
    localparam int unsigned     BYTE_SHIFT  = $clog2(BURST_BYTES);
    localparam int unsigned     NUM_BURSTS  = (2 ** ROM_ADDR_W) / BURST_LEN;
    localparam int unsigned     BC_W        = ROM_ADDR_W + 1;
    localparam logic [BC_W-1:0] LAST_BURST  = BC_W'(NUM_BURSTS - 1);
    localparam logic [8:0]      BEATS       = 9'(BURST_LEN);
    localparam logic [8:0]      LAST_BEAT   = 9'(BURST_LEN - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StData, StResp, StDone, StErr} state_e;

    state_e                  state_q, state_d;
    logic [BC_W-1:0]         burst_cnt_q, burst_cnt_d;
    logic [ROM_ADDR_W-1:0]   rom_ptr_q, rom_ptr_d;
    logic [8:0]              req_cnt_q, req_cnt_d;
    logic [8:0]              beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]       beat_buf_q [2];
    logic                    rd_idx_q, wr_idx_q;
    logic [1:0]              count_q;
    logic                    pend_q;
    logic                    start_copy;
    logic                    w_fire;
    logic                    rom_rd;
    logic [2:0]              occ;
    logic                    unused_bid;

    assign unused_bid = ^m_axi_bid_i;

    // A beat leaves the buffer only in DATA, so no W precedes its AW handshake.
    assign w_fire = (state_q == StData) && (count_q != 2'd0) && m_axi_wready_i;

    // Occupancy after this cycle's pop, so a read can refill the slot being freed
    // and the buffer keeps up with one beat per cycle.
    assign occ    = 3'(count_q) + 3'(pend_q) - 3'(w_fire);
    assign rom_rd = ((state_q == StAddr) || (state_q == StData)) &&
                    (req_cnt_q != BEATS) && (occ < 3'd2);

    // State and counter register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= StIdle;
            burst_cnt_q <= '0;
            rom_ptr_q   <= '0;
            req_cnt_q   <= '0;
            beat_cnt_q  <= '0;
        end else if (cke_i) begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rom_ptr_q   <= rom_ptr_d;
            req_cnt_q   <= req_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // Next-state logic and burst/beat/ROM bookkeeping.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        rom_ptr_d   = rom_ptr_q;
        req_cnt_d   = req_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        start_copy  = 1'b0;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    state_d     = StAddr;
                    start_copy  = 1'b1;
                    burst_cnt_d = '0;
                    rom_ptr_d   = '0;
                    req_cnt_d   = '0;
                    beat_cnt_d  = '0;
                end
            end
            StAddr: begin
                if (m_axi_awready_i) state_d = StData;
            end
            StData: begin
                if (w_fire) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = StResp;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 9'd1;
                    end
                end
            end
            StResp: begin
                if (m_axi_bvalid_i) begin
                    if (m_axi_bresp_i != 2'b00) begin
                        state_d = StErr;
                    end else if (burst_cnt_q == LAST_BURST) begin
                        state_d = StDone;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BC_W'(1);
                        req_cnt_d   = '0;
                        state_d     = StAddr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Reads only happen in ADDR/DATA, so this never collides with the clears above.
        if (rom_rd) begin
            rom_ptr_d = rom_ptr_q + ROM_ADDR_W'(1);
            req_cnt_d = req_cnt_q + 9'd1;
        end
    end

    // Two-entry beat buffer fed by ROM data one cycle after each read.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            beat_buf_q[0] <= '0;
            beat_buf_q[1] <= '0;
            rd_idx_q      <= 1'b0;
            wr_idx_q      <= 1'b0;
            count_q       <= 2'd0;
            pend_q        <= 1'b0;
        end else if (cke_i) begin
            if (start_copy) begin
                beat_buf_q[0] <= '0;
                beat_buf_q[1] <= '0;
                rd_idx_q      <= 1'b0;
                wr_idx_q      <= 1'b0;
                count_q       <= 2'd0;
                pend_q        <= 1'b0;
            end else begin
                pend_q <= rom_rd;
                if (pend_q) begin
                    beat_buf_q[wr_idx_q] <= rom_rdata_i;
                    wr_idx_q             <= ~wr_idx_q;
                end
                if (w_fire) rd_idx_q <= ~rd_idx_q;
                count_q <= 2'(3'(count_q) + 3'(pend_q) - 3'(w_fire));
            end
        end
    end

`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
    localparam int unsigned N_SLICES = (DATA_W + 31) / 32;
    localparam int unsigned PAD_W    = N_SLICES * 32;

    logic [31:0] checksum_q;

    // Wide beats fold by XOR of 32-bit slices; narrow beats are zero-extended.
    function automatic logic [31:0] fold(input logic [DATA_W-1:0] d);
        logic [PAD_W-1:0] pad;
        logic [31:0]      acc;
        pad = PAD_W'(d);
        acc = '0;
        for (int i = 0; i < int'(N_SLICES); i++) acc = acc ^ pad[i*32 +: 32];
        return acc;
    endfunction

    // Wrap-around sum of every accepted W beat, cleared on each start.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            checksum_q <= '0;
        end else if (cke_i) begin
            if (start_copy) checksum_q <= '0;
            else if (w_fire) checksum_q <= checksum_q + fold(m_axi_wdata_o);
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = 32'd0;
`endif

    assign busy_o      = (state_q == StAddr) || (state_q == StData) || (state_q == StResp);
    assign done_o      = (state_q == StDone);
    assign error_o     = (state_q == StErr);
    assign cpu_reset_o = (state_q != StDone);

    assign rom_en_o   = rom_rd;
    assign rom_addr_o = rom_ptr_q;

    assign m_axi_awid_o    = '0;
    assign m_axi_awaddr_o  = ADDR_W'(DEST_BASE) + (ADDR_W'(burst_cnt_q) << BYTE_SHIFT);
    assign m_axi_awlen_o   = 8'(BURST_LEN - 1);
    assign m_axi_awsize_o  = 3'($clog2(STRB_W));
    assign m_axi_awburst_o = 2'b01;
    assign m_axi_awvalid_o = (state_q == StAddr);

    assign m_axi_wdata_o  = beat_buf_q[rd_idx_q];
    assign m_axi_wstrb_o  = '1;
    assign m_axi_wvalid_o = (state_q == StData) && (count_q != 2'd0);
    assign m_axi_wlast_o  = (state_q == StData) && (beat_cnt_q == LAST_BEAT);
    assign m_axi_bready_o = (state_q == StResp);

endmodule

// File: tb/tb_boot_ram_loader.sv
// Bench for boot_ram_loader: 64-word image, 16-beat bursts, AXI slave + ROM models.
module tb_boot_ram_loader;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned AXI_ID_W   = 8;
    localparam int unsigned ROM_ADDR_W = 6;
    localparam int unsigned BURST_LEN  = 16;
    localparam int unsigned WORDS      = 64;
    localparam int unsigned NBURST     = WORDS / BURST_LEN;

    logic                  clk = 1'b0;
    logic                  arst_n = 1'b0;
    logic                  cke = 1'b1;
    logic                  start = 1'b0;
    logic                  busy, done, error, cpu_reset;
    logic [31:0]           checksum;
    logic                  rom_en;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0]     rom_rdata = '0;
    logic [AXI_ID_W-1:0]   awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready = 1'b0;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast, wvalid;
    logic                  wready = 1'b0;
    logic [1:0]            bresp = 2'b00;
    logic                  bvalid = 1'b0;
    logic                  bready;

    always #5 clk = ~clk;

    boot_ram_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ID_W(AXI_ID_W),
        .ROM_ADDR_W(ROM_ADDR_W), .BURST_LEN(BURST_LEN), .DEST_BASE(0)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .start_i(start),
        .busy_o(busy), .done_o(done), .error_o(error), .cpu_reset_o(cpu_reset),
        .checksum_o(checksum), .rom_en_o(rom_en), .rom_addr_o(rom_addr),
        .rom_rdata_i(rom_rdata), .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr),
        .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize), .m_axi_awburst_o(awburst),
        .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready), .m_axi_wdata_o(wdata),
        .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast), .m_axi_wvalid_o(wvalid),
        .m_axi_wready_i(wready), .m_axi_bid_i(8'h00), .m_axi_bresp_i(bresp),
        .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference image and the memory the slave writes into.
    logic [31:0] rom_mem [WORDS];
    logic [31:0] ram     [WORDS];

    // Slave knobs and observations.
    int          aw_delay = 0;
    int          wready_pct = 100;
    int          err_burst = -1;
    int          aw_wait = 0;
    bit          aw_open = 0;
    bit          b_pending = 0;
    int          beat_in_burst = 0;
    logic [31:0] cur_addr = '0;
    int          b_done = 0;
    int          beats = 0;
    logic [31:0] aw_log [$];
    int          wlast_log [$];
    int          wlast_bad = 0;
    int          w_before_aw = 0;
    int          w_unstable = 0;
    int          aw_unstable = 0;
    int          reset_fall_b = -1;
    logic        prev_wvalid = 0, prev_wready = 0, prev_awvalid = 0, prev_awready = 0;
    logic        prev_cpu_reset = 1;
    logic [31:0] prev_wdata = '0, prev_awaddr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Synchronous ROM: data one cycle after the enable.
    initial forever begin
        @(posedge clk);
        if (rom_en === 1'b1) rom_rdata <= rom_mem[rom_addr];
    end

    // AXI write slave, evaluated at the falling edge: outputs are stable here, and
    // any valid&ready seen now completes at the next rising edge.
    task automatic slave_step();
        int idx;
        if (!arst_n) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
            aw_open = 0; aw_wait = 0; b_pending = 0; beat_in_burst = 0;
            prev_wvalid = 0; prev_awvalid = 0; prev_cpu_reset = 1;
            return;
        end
        if (prev_wvalid && !prev_wready && (!wvalid || wdata !== prev_wdata)) w_unstable++;
        if (prev_awvalid && !prev_awready && (!awvalid || awaddr !== prev_awaddr)) aw_unstable++;
        if (wvalid && !aw_open) w_before_aw++;
        if (prev_cpu_reset && cpu_reset === 1'b0) reset_fall_b = b_done;
        prev_cpu_reset = cpu_reset;

        bvalid = b_pending;
        bresp  = (b_done == err_burst) ? 2'b10 : 2'b00;
        if (bvalid && bready) begin
            b_pending = 0;
            b_done++;
        end

        awready = awvalid && (aw_wait >= aw_delay);
        if (awvalid && !awready) aw_wait++;
        if (awvalid && awready) begin
            aw_log.push_back(awaddr);
            cur_addr = awaddr;
            beat_in_burst = 0;
            aw_open = 1;
            aw_wait = 0;
        end

        wready = ($urandom_range(0, 99) < wready_pct);
        if (wvalid && wready) begin
            idx = int'(cur_addr >> 2) + beat_in_burst;
            if (idx >= 0 && idx < int'(WORDS)) ram[idx] = wdata;
            if (wlast !== (beat_in_burst == int'(BURST_LEN) - 1)) wlast_bad++;
            if (wlast === 1'b1) wlast_log.push_back(beats);
            beats++;
            beat_in_burst++;
            if (beat_in_burst == int'(BURST_LEN)) begin
                aw_open = 0;
                b_pending = 1;
            end
        end
        prev_wvalid = wvalid; prev_wready = wready; prev_wdata = wdata;
        prev_awvalid = awvalid; prev_awready = awready; prev_awaddr = awaddr;
    endtask

    initial forever begin
        @(negedge clk);
        slave_step();
    end

    task automatic start_copy();
        @(negedge clk);
        aw_log.delete();
        wlast_log.delete();
        beats = 0; b_done = 0; wlast_bad = 0; w_before_aw = 0;
        w_unstable = 0; aw_unstable = 0; reset_fall_b = -1;
        for (int i = 0; i < int'(WORDS); i++) ram[i] = 'x;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_no_timeout"}, 64'(n < 5000), 64'd1);
    endtask

    function automatic logic [31:0] image_sum();
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < int'(WORDS); i++) s = s + rom_mem[i];
        return s;
    endfunction

    // Full-copy expectations derived from the image and burst geometry.
    task automatic check_copy(input string tag);
        logic [31:0] exp_sum;
`ifdef BOOT_RAM_LOADER_CHECKSUM_EN
        exp_sum = image_sum();
`else
        exp_sum = 32'd0;
`endif
        check({tag, "_aw_count"}, 64'(aw_log.size()), 64'(NBURST));
        for (int k = 0; k < int'(NBURST) && k < aw_log.size(); k++)
            check($sformatf("%s_awaddr%0d", tag, k), 64'(aw_log[k]), 64'(k * BURST_LEN * 4));
        check({tag, "_wlast_count"}, 64'(wlast_log.size()), 64'(NBURST));
        for (int k = 0; k < int'(NBURST) && k < wlast_log.size(); k++)
            check($sformatf("%s_wlast%0d", tag, k), 64'(wlast_log[k]),
                  64'((k + 1) * BURST_LEN - 1));
        check({tag, "_wlast_bad"}, 64'(wlast_bad), 64'd0);
        check({tag, "_beats"}, 64'(beats), 64'(WORDS));
        for (int i = 0; i < int'(WORDS); i++)
            check($sformatf("%s_ram%0d", tag, i), 64'(ram[i]), 64'(rom_mem[i]));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
        check({tag, "_cpu_reset_fall_after_b"}, 64'(reset_fall_b), 64'(NBURST));
        check({tag, "_w_before_aw"}, 64'(w_before_aw), 64'd0);
        check({tag, "_w_stable"}, 64'(w_unstable), 64'd0);
        check({tag, "_aw_stable"}, 64'(aw_unstable), 64'd0);
        check({tag, "_checksum"}, 64'(checksum), 64'(exp_sum));
    endtask

    initial begin
        int n;
        for (int i = 0; i < int'(WORDS); i++) rom_mem[i] = 32'(i);
        for (int i = 0; i < int'(WORDS); i++) ram[i] = 'x;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_bready", 64'(bready), 64'd0);
        check("rst_rom_en", 64'(rom_en), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Counting image, always-ready slave.
        start_copy();
        wait_end("a");
        check_copy("a");
        check("a_awlen", 64'(awlen), 64'd15);
        check("a_awsize", 64'(awsize), 64'd2);
        check("a_awburst", 64'(awburst), 64'd1);
        check("a_wstrb", 64'(wstrb), 64'hF);
        check("a_awid", 64'(awid), 64'd0);

        // Random image, throttled W, late AW, stray start during the second burst.
        for (int i = 0; i < int'(WORDS); i++) rom_mem[i] = $urandom;
        aw_delay = 5;
        wready_pct = 50;
        start_copy();
        n = 0;
        while (aw_log.size() < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("b_reach_burst2", 64'(n < 2000), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b_busy_after_stray_start", 64'(busy), 64'd1);
        wait_end("b");
        check_copy("b");

        // Error response on the second burst.
        for (int i = 0; i < int'(WORDS); i++) rom_mem[i] = $urandom;
        aw_delay = 0;
        wready_pct = 70;
        err_burst = 1;
        start_copy();
        wait_end("e");
        repeat (10) @(negedge clk);
        check("e_error", 64'(error), 64'd1);
        check("e_done", 64'(done), 64'd0);
        check("e_busy", 64'(busy), 64'd0);
        check("e_cpu_reset", 64'(cpu_reset), 64'd1);
        check("e_awvalid", 64'(awvalid), 64'd0);
        check("e_aw_count", 64'(aw_log.size()), 64'd2);
        check("e_beats", 64'(beats), 64'(2 * BURST_LEN));
        err_burst = -1;
        start_copy();
        check("e_error_cleared", 64'(error), 64'd0);
        wait_end("e2");
        check_copy("e2");

        // Asynchronous reset in the middle of the first burst.
        for (int i = 0; i < int'(WORDS); i++) rom_mem[i] = $urandom;
        wready_pct = 100;
        start_copy();
        n = 0;
        while (beats < 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("r_reach_beat7", 64'(n < 2000), 64'd1);
        #2 arst_n = 1'b0;
        #1;
        check("r_awvalid", 64'(awvalid), 64'd0);
        check("r_wvalid", 64'(wvalid), 64'd0);
        check("r_bready", 64'(bready), 64'd0);
        check("r_cpu_reset", 64'(cpu_reset), 64'd1);
        check("r_busy", 64'(busy), 64'd0);
        check("r_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_copy();
        wait_end("r");
        check_copy("r");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before 1000000");
        $fatal(1, "watchdog");
    end

endmodule
